pq_buffer_ctrl: RTL and testbench
=================================

// Module: pq_buffer_ctrl
// PURPOSE
//  Sequencer on the control side of the ping-pong (pq) spike buffer. Owns the bank-select
//  (ctrl) and the clear sweep, and muxes the producer write port onto buffer write port 1.
//  Swaps banks at timestep boundaries using a 4-phase req/ack handshake with the timestep
//  scheduler. Sits between the neuron/router write path and the pq buffer instance.
// PARAMETERS
//  DATA_WIDTH  8   buffer word width
//  ADDR_WIDTH  4   buffer address width; clear sweep covers 2**ADDR_WIDTH words
//  TS_WIDTH    16  width of timestep (swap) counter
// PORTS
//  clk           in   1           clock
//  rst           in   1           synchronous, active-high reset
//  clear_req     in   1           pulse: zero both banks
//  swap_req      in   1           level: request bank swap; hold high until swap_ack
//  rd_idle       in   1           consumer not mid-read; swap allowed only when high
//  wr_en         in   1           producer write strobe
//  wr_addr       in   ADDR_WIDTH  producer write address
//  din           in   DATA_WIDTH  producer write data
//  wr_rdy        out  1           producer write accepted this cycle when high
//  swap_ack      out  1           4-phase ack; high from swap until swap_req low
//  busy          out  1           clear sweep in progress
//  ts_cnt        out  TS_WIDTH    completed swaps, wraps modulo 2**TS_WIDTH
//  buf_ctrl      out  1           to buffer ctrl (bank select)
//  buf_clear     out  1           to buffer clear
//  buf_wr_en1    out  1           to buffer wr_en1
//  buf_wr_addr1  out  ADDR_WIDTH  to buffer wr_addr1
//  buf_din1      out  DATA_WIDTH  to buffer din1
// BEHAVIOUR
//  - Reset values: state=INIT, buf_ctrl=1, buf_clear=0, busy=0, swap_ack=0, ts_cnt=0,
//    clr_addr=0, wr_rdy=0, buf_wr_en1=0, buf_wr_addr1=0, buf_din1=0.
//  - State machine INIT -> (CLEAR|RUN), CLEAR -> RUN, RUN -> (CLEAR|SWAP), SWAP -> RUN.
//  - CLEAR: buf_clear=1, busy=1, buf_wr_en1=1, buf_wr_addr1=clr_addr, buf_din1=0.
//    clr_addr steps 0..2**ADDR_WIDTH-1, one word per cycle. Exactly 2**ADDR_WIDTH cycles.
//    Last word -> RUN, clr_addr back to 0. buf_ctrl and ts_cnt are unchanged by a clear.
//  - clear_req seen in RUN at edge n: buf_clear high in cycles n+1 .. n+2**ADDR_WIDTH.
//    clear_req during CLEAR or SWAP is ignored (not queued).
//  - RUN: wr_rdy=1. buf_wr_en1=wr_en, buf_wr_addr1=wr_addr, buf_din1=din (combinational).
//  - Swap accepted in RUN when swap_req & rd_idle & !wr_en & !clear_req.
//    Next edge: buf_ctrl toggles, ts_cnt+1 (wraps), swap_ack=1, state=SWAP.
//  - SWAP: wr_rdy=1, writes pass through to the new bank. swap_ack stays high while
//    swap_req=1. First cycle with swap_req=0 -> swap_ack=0 next edge, state=RUN.
//    This rules out a double swap on a held request.
//  - Swap held pending (no ack) while rd_idle=0 or wr_en=1. Request stays registered.
//  - clear_req and swap_req together in RUN: clear wins. Swap is taken after CLEAR ends
//    if swap_req is still high.
//  - wr_rdy=0 in INIT and CLEAR: buf_wr_en1 forced 0, producer writes dropped.
//  - rst at any time, including mid-sweep: abort and return to reset values; the
//    sweep restarts from addr 0 if enabled.
//  - Read ports of the buffer are not muxed here; the consumer drives them directly.
// CONFIGURATION
//  PQ_INIT_CLEAR_EN defined: INIT -> CLEAR on the first cycle after rst deasserts.
//    Both banks are zeroed before first use; wr_rdy rises after 2**ADDR_WIDTH+1 cycles.
//  PQ_INIT_CLEAR_EN undefined: INIT -> RUN on the first cycle after rst deasserts, so
//    wr_rdy=1 one cycle after reset. Clearing happens only on clear_req.
// TESTING
//  1 Reset, PQ_INIT_CLEAR_EN on, ADDR_WIDTH=4 -> buf_clear=1 for 16 cycles, buf_wr_addr1
//    0..15, buf_din1=0. Then wr_rdy=1 and buf_ctrl=1.
//  2 RUN, swap_req=1, rd_idle=1, wr_en=0 -> next cycle buf_ctrl=0, ts_cnt=1, swap_ack=1.
//    Hold swap_req 5 cycles -> exactly 1 toggle. Drop req -> swap_ack=0 next cycle.
//  3 swap_req=1, rd_idle=0 for 10 cycles -> no toggle, swap_ack=0. rd_idle=1 -> toggle next cycle.
//  4 clear_req and swap_req in the same RUN cycle -> 16-cycle clear, buf_ctrl unchanged.
//    Then swap: buf_ctrl toggles, ts_cnt+1.
//  5 wr_en=1, addr=5, din=0xA5 during CLEAR -> buf_wr_en1 carries only clear writes, wr_rdy=0.
//    Same write in RUN -> buf_wr_addr1=5, buf_din1=0xA5.
//  6 rst asserted at clear word 7 -> reset values next cycle, sweep restarts at 0.
//    TS_WIDTH=2, 4 swaps -> ts_cnt wraps to 0.

Source files
------------

// File: rtl/pq_buffer_ctrl_if.sv
// Handshake and buffer-port bundle between the producer/scheduler side and pq_buffer_ctrl.
// slave: the controller's view; master: the driving environment's view.
interface pq_buffer_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TS_WIDTH   = 16
);
  logic                  clear_req;
  logic                  swap_req;
  logic                  rd_idle;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_rdy;
  logic                  swap_ack;
  logic                  busy;
  logic [TS_WIDTH-1:0]   ts_cnt;
  logic                  buf_ctrl;
  logic                  buf_clear;
  logic                  buf_wr_en1;
  logic [ADDR_WIDTH-1:0] buf_wr_addr1;
  logic [DATA_WIDTH-1:0] buf_din1;

  modport master (
    output clear_req, swap_req, rd_idle, wr_en, wr_addr, din,
    input  wr_rdy, swap_ack, busy, ts_cnt, buf_ctrl, buf_clear, buf_wr_en1, buf_wr_addr1,
           buf_din1
  );

  modport slave (
    input  clear_req, swap_req, rd_idle, wr_en, wr_addr, din,
    output wr_rdy, swap_ack, busy, ts_cnt, buf_ctrl, buf_clear, buf_wr_en1, buf_wr_addr1,
           buf_din1
  );
endinterface

// File: rtl/pq_buffer_ctrl.sv
// Ping-pong spike buffer sequencer: bank select, clear sweep, 4-phase swap handshake.
// Define PQ_INIT_CLEAR_EN to sweep both banks to zero right after reset.
module pq_buffer_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TS_WIDTH   = 16
) (
  input logic              clk,
  input logic              rst,
  pq_buffer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StInit, StClear, StRun, StSwap} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  buf_ctrl_q, buf_ctrl_d;
  logic [TS_WIDTH-1:0]   ts_cnt_q, ts_cnt_d;
  logic                  swap_ack_q, swap_ack_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      clr_addr_q <= '0;
      buf_ctrl_q <= 1'b1;
      ts_cnt_q   <= '0;
      swap_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      buf_ctrl_q <= buf_ctrl_d;
      ts_cnt_q   <= ts_cnt_d;
      swap_ack_q <= swap_ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    buf_ctrl_d = buf_ctrl_q;
    ts_cnt_d   = ts_cnt_q;
    swap_ack_d = swap_ack_q;
    case (state_q)
      StInit: begin
`ifdef PQ_INIT_CLEAR_EN
        state_d = StClear;
`else
        state_d = StRun;
`endif
      end
      StClear: begin
        if (clr_addr_q == LastAddr) begin
          state_d    = StRun;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      StRun: begin
        // Clear has priority; a still-held swap request is taken once the sweep ends.
        if (bus.clear_req) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end else if (bus.swap_req && bus.rd_idle && !bus.wr_en) begin
          state_d    = StSwap;
          buf_ctrl_d = ~buf_ctrl_q;
          ts_cnt_d   = ts_cnt_q + 1'b1;
          swap_ack_d = 1'b1;
        end
      end
      StSwap: begin
        // Stay here until the request drops so a held request swaps only once.
        if (!bus.swap_req) begin
          state_d    = StRun;
          swap_ack_d = 1'b0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    bus.wr_rdy       = 1'b0;
    bus.busy         = 1'b0;
    bus.buf_clear    = 1'b0;
    bus.buf_wr_en1   = 1'b0;
    bus.buf_wr_addr1 = '0;
    bus.buf_din1     = '0;
    case (state_q)
      StClear: begin
        bus.busy         = 1'b1;
        bus.buf_clear    = 1'b1;
        bus.buf_wr_en1   = 1'b1;
        bus.buf_wr_addr1 = clr_addr_q;
      end
      StRun, StSwap: begin
        bus.wr_rdy       = 1'b1;
        bus.buf_wr_en1   = bus.wr_en;
        bus.buf_wr_addr1 = bus.wr_addr;
        bus.buf_din1     = bus.din;
      end
      default: ;
    endcase
  end

  assign bus.swap_ack = swap_ack_q;
  assign bus.buf_ctrl = buf_ctrl_q;
  assign bus.ts_cnt   = ts_cnt_q;

endmodule

// File: tb/tb_pq_buffer_ctrl.sv
// Bench for pq_buffer_ctrl: directed scenarios then random traffic, every cycle compared
// against a cycle-count model of the sequencer (honours PQ_INIT_CLEAR_EN).
module tb_pq_buffer_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int TW    = 2;
  localparam int WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pq_buffer_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TS_WIDTH(TW)) bus ();

  pq_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TS_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Model: what the sequencer is doing, in plain counts rather than states.
  bit m_valid = 0;
  bit m_init;
  int m_clear_left;
  bit m_bank;
  int m_swaps;
  bit m_ack;

`ifdef PQ_INIT_CLEAR_EN
  localparam bit InitClear = 1'b1;
`else
  localparam bit InitClear = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic            ready, clearing;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_din;
    logic            e_en;
    clearing = (m_clear_left > 0);
    ready    = !m_init && !clearing;
    e_en     = clearing ? 1'b1 : (ready ? bus.wr_en : 1'b0);
    e_addr   = clearing ? AW'(WORDS - m_clear_left) : (ready ? bus.wr_addr : '0);
    e_din    = ready ? bus.din : '0;
    chk("wr_rdy", 32'(bus.wr_rdy), 32'(ready));
    chk("busy", 32'(bus.busy), 32'(clearing));
    chk("buf_clear", 32'(bus.buf_clear), 32'(clearing));
    chk("swap_ack", 32'(bus.swap_ack), 32'(m_ack));
    chk("buf_ctrl", 32'(bus.buf_ctrl), 32'(m_bank));
    chk("ts_cnt", 32'(bus.ts_cnt), 32'(m_swaps));
    chk("buf_wr_en1", 32'(bus.buf_wr_en1), 32'(e_en));
    chk("buf_wr_addr1", 32'(bus.buf_wr_addr1), 32'(e_addr));
    chk("buf_din1", 32'(bus.buf_din1), 32'(e_din));
  endtask

  task automatic update_model();
    if (rst) begin
      m_valid = 1; m_init = 1; m_clear_left = 0; m_bank = 1; m_swaps = 0; m_ack = 0;
    end else if (!m_valid) begin
      // nothing known before the first reset
    end else if (m_init) begin
      m_init = 0;
      m_clear_left = InitClear ? WORDS : 0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (m_ack) begin
      if (!bus.swap_req) m_ack = 0;
    end else if (bus.clear_req) begin
      m_clear_left = WORDS;
    end else if (bus.swap_req && bus.rd_idle && !bus.wr_en) begin
      m_bank  = ~m_bank;
      m_swaps = (m_swaps + 1) % (1 << TW);
      m_ack   = 1;
    end
  endtask

  // One clock: compare outputs mid-cycle, advance model, then land #1 after the edge.
  task automatic cycle();
    @(negedge clk);
    if (m_valid) check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear_req = 0; bus.swap_req = 0; bus.rd_idle = 1; bus.wr_en = 0;
    bus.wr_addr = '0; bus.din = '0;
  endtask

  task automatic settle_to_run();
    idle_inputs();
    repeat (WORDS + 2) cycle();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) cycle();
    chk("reset_buf_ctrl", 32'(bus.buf_ctrl), 32'd1);
    chk("reset_wr_rdy", 32'(bus.wr_rdy), 32'd0);
    rst = 0;

    // Power-up: optional sweep, then ready with bank 1
    settle_to_run();
    chk("init_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    chk("init_buf_ctrl", 32'(bus.buf_ctrl), 32'd1);

    // Held swap request toggles exactly once
    bus.swap_req = 1;
    cycle();
    chk("swap_ctrl", 32'(bus.buf_ctrl), 32'd0);
    chk("swap_ts", 32'(bus.ts_cnt), 32'd1);
    chk("swap_ack", 32'(bus.swap_ack), 32'd1);
    repeat (5) cycle();
    chk("swap_held_ctrl", 32'(bus.buf_ctrl), 32'd0);
    bus.swap_req = 0;
    cycle();
    chk("swap_ack_drop", 32'(bus.swap_ack), 32'd0);

    // Swap pending while consumer is mid-read
    bus.swap_req = 1; bus.rd_idle = 0;
    repeat (10) cycle();
    chk("pend_ctrl", 32'(bus.buf_ctrl), 32'd0);
    chk("pend_ack", 32'(bus.swap_ack), 32'd0);
    bus.rd_idle = 1;
    cycle();
    chk("pend_go_ctrl", 32'(bus.buf_ctrl), 32'd1);
    chk("pend_go_ts", 32'(bus.ts_cnt), 32'd2);
    bus.swap_req = 0;
    repeat (2) cycle();

    // Clear beats swap; swap follows the sweep
    bus.clear_req = 1; bus.swap_req = 1;
    cycle();
    bus.clear_req = 0;
    chk("clr_busy", 32'(bus.busy), 32'd1);
    repeat (WORDS - 1) cycle();
    chk("clr_last_word", 32'(bus.buf_wr_addr1), 32'(WORDS - 1));
    chk("clr_ctrl_kept", 32'(bus.buf_ctrl), 32'd1);
    repeat (2) cycle();
    chk("post_clr_swap_ctrl", 32'(bus.buf_ctrl), 32'd0);
    chk("post_clr_swap_ts", 32'(bus.ts_cnt), 32'd3);
    bus.swap_req = 0;
    repeat (2) cycle();

    // Producer writes dropped during clear, passed through in run
    bus.clear_req = 1;
    cycle();
    bus.clear_req = 0; bus.wr_en = 1; bus.wr_addr = 4'd5; bus.din = 8'hA5;
    repeat (3) cycle();
    chk("clr_wr_rdy", 32'(bus.wr_rdy), 32'd0);
    chk("clr_din_zero", 32'(bus.buf_din1), 32'd0);
    repeat (WORDS) cycle();
    chk("run_addr", 32'(bus.buf_wr_addr1), 32'd5);
    chk("run_din", 32'(bus.buf_din1), 32'hA5);
    idle_inputs();
    cycle();

    // Reset mid-sweep at word 7
    bus.clear_req = 1;
    cycle();
    bus.clear_req = 0;
    repeat (7) cycle();
    chk("mid_word7", 32'(bus.buf_wr_addr1), 32'd7);
    rst = 1;
    cycle();
    chk("mid_rst_ctrl", 32'(bus.buf_ctrl), 32'd1);
    chk("mid_rst_ts", 32'(bus.ts_cnt), 32'd0);
    chk("mid_rst_clear", 32'(bus.buf_clear), 32'd0);
    rst = 0;
    settle_to_run();
    bus.clear_req = 1;
    cycle();
    bus.clear_req = 0;
    chk("restart_addr0", 32'(bus.buf_wr_addr1), 32'd0);
    settle_to_run();

    // Four swaps wrap a 2-bit counter
    for (int i = 0; i < 4; i++) begin
      bus.swap_req = 1;
      cycle();
      bus.swap_req = 0;
      repeat (2) cycle();
    end
    chk("ts_wrap", 32'(bus.ts_cnt), 32'd0);
    chk("ts_wrap_ctrl", 32'(bus.buf_ctrl), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus.clear_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) bus.swap_req = ~bus.swap_req;
      bus.rd_idle   = ($urandom_range(0, 9) < 7);
      bus.wr_en     = ($urandom_range(0, 9) < 4);
      bus.wr_addr   = AW'($urandom);
      bus.din       = DW'($urandom);
      cycle();
    end
    rst = 0;
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
